// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned WORD_SIZE = 16;

  localparam logic [WORD_SIZE-1:0] INST_NOP = 16'hF01C;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding buffer for an instruction returned while the pipe is stalled.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 drain,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data,
  output logic                 full
);

  // load wins over drain so a same-cycle refill is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
      full <= 1'b0;
    end else if (load) begin
      data <= data_in;
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request FSM and the IF/ID pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pc_write,
  input  logic                 ir_write,
  input  logic                 flush,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] ir_id,
  output logic [WORD_SIZE-1:0] pc_id,
  output logic                 valid_id,
  output logic                 fetch_stall
);

  fetch_state_e         state, state_n;
  logic [WORD_SIZE-1:0] pc, pc_n, pc_inc;
  logic                 readm_n;
  logic [WORD_SIZE-1:0] ir_n, pcid_n;
  logic                 valid_n;
  logic                 buf_load, buf_drain, buf_full;
  logic [WORD_SIZE-1:0] buf_data;
  logic                 mem_done, avail, advance;
  logic [WORD_SIZE-1:0] avail_data;

  fetch_buffer u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (buf_load),
    .drain   (buf_drain),
    .data_in (i_data),
    .data    (buf_data),
    .full    (buf_full)
  );

  // A response only counts while our own request is on the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH;
      pc       <= '0;
      i_readM  <= 1'b0;
      ir_id    <= INST_NOP;
      pc_id    <= '0;
      valid_id <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      i_readM  <= readm_n;
      ir_id    <= ir_n;
      pc_id    <= pcid_n;
      valid_id <= valid_n;
    end
  end

  assign i_address = pc;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ir_n        = ir_id;
    pcid_n      = pc_id;
    valid_n     = valid_id;
    buf_load    = 1'b0;
    buf_drain   = 1'b0;
    fetch_stall = 1'b0;

    pc_inc     = pc + WORD_SIZE'(1);
    mem_done   = (state == FETCH) && i_readM && i_ready;
    avail      = mem_done || ((state == HOLD) && buf_full);
    avail_data = (state == HOLD) ? buf_data : i_data;
    advance    = avail && ir_write && pc_write && !flush;

    if (redirect_valid) begin
      pc_n      = redirect_pc;
      buf_drain = 1'b1;
      ir_n      = INST_NOP;
      valid_n   = 1'b0;
      unique case (state)
        FETCH:   state_n = (i_readM && !i_ready) ? DISCARD : FETCH;
        HOLD:    state_n = FETCH;
        DISCARD: state_n = i_ready ? FETCH : DISCARD;
        default: state_n = FETCH;
      endcase
    end else begin
      // IF/ID update; flush only matters when the register is being written
      if (ir_write) begin
        fetch_stall = !avail;
        if (advance) begin
          ir_n    = avail_data;
          pcid_n  = pc_inc;
          valid_n = 1'b1;
        end else begin
          ir_n    = INST_NOP;
          valid_n = 1'b0;
        end
      end
      if (advance) pc_n = pc_inc;

      unique case (state)
        FETCH: begin
          if (mem_done && !advance && (!ir_write || !pc_write)) begin
            buf_load = 1'b1;
            state_n  = HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            buf_drain = 1'b1;
            state_n   = FETCH;
          end
        end
        DISCARD: begin
          if (i_ready) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end

    readm_n = (state_n == FETCH);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus reset corner sequences.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [15:0] N = INST_NOP;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_write, ir_write, flush, redirect_valid, i_ready;
  logic [15:0] redirect_pc, i_data;
  logic        i_readM, valid_id, fetch_stall;
  logic [15:0] i_address, ir_id, pc_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pw, iw, fl, rv;
    logic [15:0] rpc;
    logic        rdy;
    logic [15:0] dat;
    logic        stall;
    logic        readm;
    logic [15:0] addr, ir, pcid;
    logic        vld;
  } vec_t;

  vec_t tbl[$];

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_write       (pc_write),
    .ir_write       (ir_write),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .i_readM        (i_readM),
    .i_address      (i_address),
    .i_data         (i_data),
    .i_ready        (i_ready),
    .ir_id          (ir_id),
    .pc_id          (pc_id),
    .valid_id       (valid_id),
    .fetch_stall    (fetch_stall)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic pw, logic iw, logic fl, logic rv, logic [15:0] rpc,
                              logic rdy, logic [15:0] dat, logic stall, logic readm,
                              logic [15:0] addr, logic [15:0] ir, logic [15:0] pcid,
                              logic vld);
    vec_t v;
    v.pw = pw; v.iw = iw; v.fl = fl; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.dat = dat;
    v.stall = stall; v.readm = readm; v.addr = addr; v.ir = ir; v.pcid = pcid; v.vld = vld;
    return v;
  endfunction

  task automatic chk16(string nm, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk1(string nm, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic drive(logic pw, logic iw, logic fl, logic rv, logic [15:0] rpc,
                       logic rdy, logic [15:0] dat);
    pc_write = pw; ir_write = iw; flush = fl; redirect_valid = rv;
    redirect_pc = rpc; i_ready = rdy; i_data = dat;
  endtask

  task automatic chk_regs(string tag, logic readm, logic [15:0] addr, logic [15:0] ir,
                          logic [15:0] pcid, logic vld);
    chk1 ({tag, " i_readM"},   i_readM,   readm);
    chk16({tag, " i_address"}, i_address, addr);
    chk16({tag, " ir_id"},     ir_id,     ir);
    chk16({tag, " pc_id"},     pc_id,     pcid);
    chk1 ({tag, " valid_id"},  valid_id,  vld);
  endtask

  initial begin
    //         pw iw fl rv rpc      rdy dat       stall rdM addr      ir        pc_id     vld
    tbl.push_back(mk(1,0,0,0,16'h0000,1,16'h0000, 0, 1,16'h0000,N,        16'h0000,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h1000, 0, 1,16'h0001,16'h1000,16'h0001,1));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h1001, 0, 1,16'h0002,16'h1001,16'h0002,1));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h1002, 0, 1,16'h0003,16'h1002,16'h0003,1));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h1003, 0, 1,16'h0004,16'h1003,16'h0004,1));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h1004, 0, 1,16'h0005,16'h1004,16'h0005,1));
    // three-cycle latency at pc=5
    tbl.push_back(mk(1,1,0,0,16'h0000,0,16'h0000, 1, 1,16'h0005,N,        16'h0005,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,0,16'h0000, 1, 1,16'h0005,N,        16'h0005,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h6A01, 0, 1,16'h0006,16'h6A01,16'h0006,1));
    // ir_write low on completion -> HOLD, IF/ID frozen, stray ready ignored
    tbl.push_back(mk(1,0,0,0,16'h0000,1,16'h4123, 0, 0,16'h0006,16'h6A01,16'h0006,1));
    tbl.push_back(mk(1,0,0,0,16'h0000,1,16'hDEAD, 0, 0,16'h0006,16'h6A01,16'h0006,1));
    tbl.push_back(mk(1,1,0,0,16'h0000,0,16'h0000, 0, 1,16'h0007,16'h4123,16'h0007,1));
    // flush beats a ready instruction; flush with ir_write low is ignored
    tbl.push_back(mk(1,1,1,0,16'h0000,1,16'h5555, 0, 1,16'h0007,N,        16'h0007,0));
    tbl.push_back(mk(0,0,1,0,16'h0000,0,16'h0000, 0, 1,16'h0007,N,        16'h0007,0));
    // redirect with a read outstanding; stale ready two cycles later
    tbl.push_back(mk(1,1,0,1,16'h0040,0,16'h0000, 0, 0,16'h0040,N,        16'h0007,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,0,16'h0000, 1, 0,16'h0040,N,        16'h0007,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'hFFFF, 1, 1,16'h0040,N,        16'h0007,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h7777, 0, 1,16'h0041,16'h7777,16'h0041,1));
    // redirect to 16'hFFFF, then the pc wraps
    tbl.push_back(mk(1,1,0,1,16'hFFFF,1,16'h2222, 0, 1,16'hFFFF,N,        16'h0041,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h3333, 0, 1,16'h0000,16'h3333,16'h0000,1));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h0A0A, 0, 1,16'h0001,16'h0A0A,16'h0001,1));
    // second redirect while discarding
    tbl.push_back(mk(1,1,0,1,16'h0100,0,16'h0000, 0, 0,16'h0100,N,        16'h0001,0));
    tbl.push_back(mk(1,1,0,1,16'h0200,0,16'h0000, 0, 0,16'h0200,N,        16'h0001,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'hBEEF, 1, 1,16'h0200,N,        16'h0001,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h1234, 0, 1,16'h0201,16'h1234,16'h0201,1));
    // pc_write low -> HOLD; redirect in HOLD drops the buffered word
    tbl.push_back(mk(0,1,0,0,16'h0000,1,16'h5678, 0, 0,16'h0201,N,        16'h0201,0));
    tbl.push_back(mk(1,1,0,1,16'h0300,0,16'h0000, 0, 1,16'h0300,N,        16'h0201,0));
    tbl.push_back(mk(1,1,0,0,16'h0000,1,16'h9ABC, 0, 1,16'h0301,16'h9ABC,16'h0301,1));

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 1'b0, 16'h0000, N, 16'h0000, 1'b0);
    reset_n = 1'b1;

    // inputs applied just after the edge, outputs sampled before the next one
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pw, tbl[i].iw, tbl[i].fl, tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].dat);
      @(negedge clk);
      chk1($sformatf("v%0d fetch_stall", i), fetch_stall, tbl[i].stall);
      @(posedge clk);
      #1;
      chk_regs($sformatf("v%0d", i), tbl[i].readm, tbl[i].addr, tbl[i].ir, tbl[i].pcid,
               tbl[i].vld);
    end

    // enter HOLD, then drop reset between edges
    drive(1, 0, 0, 0, 16'h0000, 1, 16'h1111);
    @(posedge clk);
    #1;
    chk_regs("hold", 1'b0, 16'h0301, 16'h9ABC, 16'h0301, 1'b1);
    drive(1, 1, 0, 0, 16'h0000, 1, 16'hBAD0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_regs("async_reset", 1'b0, 16'h0000, N, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    chk_regs("in_reset", 1'b0, 16'h0000, N, 16'h0000, 1'b0);
    reset_n = 1'b1;

    // late ready right after reset is ignored; first request follows
    @(negedge clk);
    chk1("post_reset fetch_stall", fetch_stall, 1'b1);
    @(posedge clk);
    #1;
    chk_regs("post_reset", 1'b1, 16'h0000, N, 16'h0000, 1'b0);
    drive(1, 1, 0, 0, 16'h0000, 1, 16'h0F0F);
    @(posedge clk);
    #1;
    chk_regs("first_fetch", 1'b1, 16'h0001, 16'h0F0F, 16'h0001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
